// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong graphics block and its game-level controller.
// The controller sits on the slave side; the graphics block and scan generator sit on the master side.
interface pong_game_ctrl_if;
  logic [1:0] btn1;
  logic [1:0] btn2;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       miss;
  logic       hit_left;
  logic       hit_right;
  logic       graph_still;
  logic       game_over;
  logic [1:0] balls_left;
  logic [7:0] rally;
  logic [1:0] state;

  modport master (
    output btn1, btn2, pix_x, pix_y, miss, hit_left, hit_right,
    input  graph_still, game_over, balls_left, rally, state
  );

  modport slave (
    input  btn1, btn2, pix_x, pix_y, miss, hit_left, hit_right,
    output graph_still, game_over, balls_left, rally, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-level controller: ball count, BCD rally counter and frame-based delay timer.
// It turns the graphics block's level events into single-cycle pulses and drives graph_still back to it.
module pong_game_ctrl #(
  parameter int BALLS_INIT   = 3,
  parameter int TIMER_FRAMES = 120,
  parameter int REFR_Y       = 481
) (
  input  logic           clk,
  input  logic           reset,
  pong_game_ctrl_if.slave bus
);

  localparam logic [1:0] ST_NEWGAME = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b01;
  localparam logic [1:0] ST_NEWBALL = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  localparam logic [1:0] BALLS_START = 2'(BALLS_INIT);
  localparam logic [7:0] TIMER_LOAD  = 8'(TIMER_FRAMES);
  localparam logic [9:0] REFR_LINE   = 10'(REFR_Y);

  localparam int EV_FRAME = 0;
  localparam int EV_BTN   = 1;
  localparam int EV_MISS  = 2;
  localparam int EV_HIT   = 3;
  localparam int EV_NUM   = 4;

  logic [EV_NUM-1:0] evt_src;
  logic [EV_NUM-1:0] evt_hist_reg;
  logic [EV_NUM-1:0] evt_pulse;

  logic       frame_tick;
  logic       btn_evt;
  logic       miss_evt;
  logic       hit_evt;

  logic [1:0] state_reg, state_next;
  logic [1:0] balls_reg, balls_next;
  logic [7:0] rally_reg, rally_next;
  logic [7:0] timer_reg, timer_next;
  logic [7:0] timer_dec;
  logic       timer_load;
  logic       graph_still_reg, graph_still_next;
  logic       game_over_reg, game_over_next;

  // The frame condition stays true while pix_x sits at 0, so only its rising edge counts.
  assign evt_src[EV_FRAME] = (bus.pix_y == REFR_LINE) && (bus.pix_x == 10'd0);
  assign evt_src[EV_BTN]   = |{bus.btn1, bus.btn2};
  assign evt_src[EV_MISS]  = bus.miss;
  assign evt_src[EV_HIT]   = bus.hit_left | bus.hit_right;

  genvar gi;
  generate
    for (gi = 0; gi < EV_NUM; gi++) begin : g_edge
      assign evt_pulse[gi] = evt_src[gi] & ~evt_hist_reg[gi];
    end
  endgenerate

  assign frame_tick = evt_pulse[EV_FRAME];
  assign btn_evt    = evt_pulse[EV_BTN];
  assign miss_evt   = evt_pulse[EV_MISS];
  assign hit_evt    = evt_pulse[EV_HIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_hist_reg <= '0;
    end else begin
      evt_hist_reg <= evt_src;
    end
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign timer_dec  = (frame_tick && (timer_reg != 8'd0)) ? timer_reg - 8'd1 : timer_reg;
  // A load on the same clock as a frame tick takes priority over the decrement.
  assign timer_next = timer_load ? TIMER_LOAD : timer_dec;

  always_comb begin
    state_next = state_reg;
    balls_next = balls_reg;
    rally_next = rally_reg;
    timer_load = 1'b0;
    case (state_reg)
      ST_NEWGAME: begin
        if (btn_evt) begin
          state_next = ST_PLAY;
          balls_next = BALLS_START;
          rally_next = 8'h00;
        end
      end
      ST_PLAY: begin
        if (miss_evt) begin
          rally_next = 8'h00;
          timer_load = 1'b1;
          if (balls_reg > 2'd1) begin
            balls_next = balls_reg - 2'd1;
            state_next = ST_NEWBALL;
          end else begin
            balls_next = 2'd0;
            state_next = ST_OVER;
          end
        end else if (hit_evt) begin
          rally_next = bcd_inc(rally_reg);
        end
      end
      ST_NEWBALL: begin
        if ((timer_reg == 8'd0) && btn_evt) begin
          state_next = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (timer_dec == 8'd0) begin
          state_next = ST_NEWGAME;
        end
      end
      default: begin
        state_next = ST_NEWGAME;
      end
    endcase
  end

  assign graph_still_next = (state_next != ST_PLAY);
  assign game_over_next   = (state_next == ST_OVER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_NEWGAME;
      balls_reg       <= BALLS_START;
      rally_reg       <= 8'h00;
      timer_reg       <= 8'd0;
      graph_still_reg <= 1'b1;
      game_over_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      balls_reg       <= balls_next;
      rally_reg       <= rally_next;
      timer_reg       <= timer_next;
      graph_still_reg <= graph_still_next;
      game_over_reg   <= game_over_next;
    end
  end

  assign bus.state       = state_reg;
  assign bus.balls_left  = balls_reg;
  assign bus.rally       = rally_reg;
  assign bus.graph_still = graph_still_reg;
  assign bus.game_over   = game_over_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed plus randomized bench for pong_game_ctrl, checked against a rule-level game model.
// Frames are abstracted: the bench parks the scan on the refresh line instead of sweeping a full raster.
module tb_pong_game_ctrl;
  localparam int BALLS_INIT   = 3;
  localparam int TIMER_FRAMES = 120;
  localparam int REFR_Y       = 481;

  localparam int S_NEWGAME = 0;
  localparam int S_PLAY    = 1;
  localparam int S_NEWBALL = 2;
  localparam int S_OVER    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .BALLS_INIT  (BALLS_INIT),
    .TIMER_FRAMES(TIMER_FRAMES),
    .REFR_Y      (REFR_Y)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Game model: rally kept as a plain decimal number, timer as an integer frame count.
  int m_state, m_balls, m_rally, m_timer;
  bit p_frame, p_btn, p_miss, p_hit;

  task automatic model_reset();
    m_state = S_NEWGAME;
    m_balls = BALLS_INIT;
    m_rally = 0;
    m_timer = 0;
    p_frame = 0; p_btn = 0; p_miss = 0; p_hit = 0;
  endtask

  task automatic model_clock();
    bit fc, bc, mc, hc, f, b, mi, h, load;
    int old_state;
    fc = (bus.pix_y == 10'(REFR_Y)) && (bus.pix_x == 10'd0);
    bc = (bus.btn1 != 2'd0) || (bus.btn2 != 2'd0);
    mc = bus.miss;
    hc = bus.hit_left || bus.hit_right;
    f  = fc && !p_frame;
    b  = bc && !p_btn;
    mi = mc && !p_miss;
    h  = hc && !p_hit;
    p_frame = fc; p_btn = bc; p_miss = mc; p_hit = hc;
    old_state = m_state;
    load = 0;
    case (old_state)
      S_NEWGAME: if (b) begin
        m_state = S_PLAY; m_balls = BALLS_INIT; m_rally = 0;
      end
      S_PLAY: if (mi) begin
        m_rally = 0; m_timer = TIMER_FRAMES; load = 1;
        if (m_balls > 1) begin m_balls--; m_state = S_NEWBALL; end
        else begin m_balls = 0; m_state = S_OVER; end
      end else if (h && m_rally < 99) begin
        m_rally++;
      end
      S_NEWBALL: if (m_timer == 0 && b) m_state = S_PLAY;
      default: ;
    endcase
    if (!load && f && m_timer > 0) m_timer--;
    if (old_state == S_OVER && m_timer == 0) m_state = S_NEWGAME;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_clock();
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"},       {6'd0, bus.state},       8'(m_state));
    check({tag, ".graph_still"}, {7'd0, bus.graph_still}, (m_state != S_PLAY) ? 8'd1 : 8'd0);
    check({tag, ".game_over"},   {7'd0, bus.game_over},   (m_state == S_OVER) ? 8'd1 : 8'd0);
    check({tag, ".balls_left"},  {6'd0, bus.balls_left},  8'(m_balls));
    check({tag, ".rally"},       bus.rally,               to_bcd(m_rally));
  endtask

  task automatic report(input string tag);
    $display("%s: state=%0d still=%0d over=%0d balls=%0d rally=%h", tag,
             bus.state, bus.graph_still, bus.game_over, bus.balls_left, bus.rally);
  endtask

  task automatic press_btn();
    bus.btn1 = 2'b01; hold(2);
    bus.btn1 = 2'b00; hold(2);
  endtask

  task automatic hit_pulse(input int n);
    bus.hit_right = 1'b1; hold(n);
    bus.hit_right = 1'b0; hold(n);
  endtask

  task automatic frames(input int count, input int hold_clks);
    repeat (count) begin
      bus.pix_y = 10'(REFR_Y); bus.pix_x = 10'd0; hold(hold_clks);
      bus.pix_x = 10'd1; hold(1);
      bus.pix_y = 10'd0; hold(1);
    end
  endtask

  initial begin
    bus.btn1 = 2'b00; bus.btn2 = 2'b00;
    bus.pix_x = 10'd0; bus.pix_y = 10'd0;
    bus.miss = 1'b0; bus.hit_left = 1'b0; bus.hit_right = 1'b0;
    model_reset();
    hold(3);
    check_model("reset");
    check("reset.still_const", {7'd0, bus.graph_still}, 8'd1);
    report("reset");
    reset = 1'b0;
    hold(2);

    // Start: state changes on the clock where the button edge is seen.
    bus.btn1 = 2'b01; step();
    check_model("start");
    check("start.state_const", {6'd0, bus.state}, 8'd1);
    check("start.still_const", {7'd0, bus.graph_still}, 8'd0);
    bus.btn1 = 2'b00; hold(2);
    report("start");

    repeat (3) hit_pulse(1000);
    check_model("rally3");
    check("rally3.const", bus.rally, 8'h03);
    repeat (7) hit_pulse(2);
    check("rally10.const", bus.rally, 8'h10);
    repeat (89) hit_pulse(2);
    check("rally99.const", bus.rally, 8'h99);
    hit_pulse(2);
    check_model("rally_sat");
    check("rally_sat.const", bus.rally, 8'h99);
    report("rally");

    bus.miss = 1'b1; frames(1, 1); hold(5); bus.miss = 1'b0; hold(2);
    check_model("miss1");
    check("miss1.balls_const", {6'd0, bus.balls_left}, 8'd2);
    check("miss1.state_const", {6'd0, bus.state}, 8'd2);
    report("miss1");

    frames(50, 1); press_btn();
    check_model("btn_f50");
    check("btn_f50.state_const", {6'd0, bus.state}, 8'd2);
    frames(70, 1); press_btn();
    check_model("btn_f120");
    check("btn_f120.state_const", {6'd0, bus.state}, 8'd1);
    report("newball_done");

    hit_pulse(2); hit_pulse(2);
    check("pre_tie.rally", bus.rally, 8'h02);
    bus.miss = 1'b1; bus.hit_left = 1'b1; step();
    check_model("tie");
    check("tie.rally_const", bus.rally, 8'h00);
    check("tie.balls_const", {6'd0, bus.balls_left}, 8'd1);
    bus.miss = 1'b0; bus.hit_left = 1'b0; hold(2);
    report("tie");

    frames(120, 1); press_btn();
    check_model("resume");
    bus.miss = 1'b1; step(); bus.miss = 1'b0; hold(2);
    check_model("over");
    check("over.game_over_const", {7'd0, bus.game_over}, 8'd1);
    check("over.balls_const", {6'd0, bus.balls_left}, 8'd0);
    report("over");

    // Scan parked at pix_x == 0 for 4 clocks per frame; buttons pressed along the way.
    for (int i = 0; i < 119; i++) begin
      frames(1, 4);
      if (i % 30 == 0) press_btn();
    end
    check_model("over_f119");
    check("over_f119.state_const", {6'd0, bus.state}, 8'd3);
    frames(1, 4);
    check_model("over_f120");
    check("over_f120.state_const", {6'd0, bus.state}, 8'd0);
    check("over_f120.game_over_const", {7'd0, bus.game_over}, 8'd0);
    report("over_end");

    press_btn();
    check_model("game2");
    bus.miss = 1'b1; step(); bus.miss = 1'b0; hold(2);
    frames(60, 4); press_btn();
    check_model("nb_f60");
    check("nb_f60.state_const", {6'd0, bus.state}, 8'd2);

    // Asynchronous reset: checked between clock edges.
    #2; reset = 1'b1; #1;
    check("areset.state", {6'd0, bus.state}, 8'd0);
    check("areset.still", {7'd0, bus.graph_still}, 8'd1);
    check("areset.over", {7'd0, bus.game_over}, 8'd0);
    check("areset.balls", {6'd0, bus.balls_left}, 8'(BALLS_INIT));
    check("areset.rally", bus.rally, 8'h00);
    model_reset();
    hold(2);
    reset = 1'b0;
    hold(1);
    check_model("post_reset");
    report("async_reset");

    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.btn1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.btn2 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bus.miss = ~bus.miss;
      if ($urandom_range(0, 5) == 0) bus.hit_left = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) bus.hit_right = 1'($urandom_range(0, 1));
      bus.pix_y = ($urandom_range(0, 2) == 0) ? 10'(REFR_Y) : 10'($urandom_range(0, 524));
      bus.pix_x = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(1, 799));
      reset = ($urandom_range(0, 2999) == 0);
      step();
      check_model("rand");
    end
    reset = 1'b0;
    report("random_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
